// File: rtl/clk_div_sequencer_if.sv
// rtl/clk_div_sequencer_if.sv - ratio handshake and divided-clock bundle for clk_div_sequencer
//
// Purpose: groups the control inputs and the divider outputs of clk_div_sequencer.
// Signals:
//   enable  : level, 1 = run the divider, 0 = stop at the next period boundary
//   div_req : ratio-change request, held until div_ack
//   div_val : requested divide ratio N, sampled while div_req = 1
//   div_ack : one-cycle pulse, request consumed
//   div_err : one-cycle pulse with div_ack, request rejected
//   clk_out : divided clock, registered
//   tick    : one-cycle pulse in the cycle clk_out rises
//   busy    : divider running or finishing its last period
// Modports: master drives the request side, slave is the divider.
interface clk_div_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             div_req;
    logic [CNT_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             tick;
    logic             busy;

    modport master (
        output enable, div_req, div_val,
        input  div_ack, div_err, clk_out, tick, busy
    );

    modport slave (
        input  enable, div_req, div_val,
        output div_ack, div_err, clk_out, tick, busy
    );
endinterface

// File: rtl/clk_div_sequencer.sv
// rtl/clk_div_sequencer.sv - glitch-free programmable clock divider with ratio-change handshake
//
// Purpose: generates clk_out = clk/N with a tick on every rising edge of clk_out.
// Ratio changes are accepted at any time but only applied at a period boundary
// (the cycle in which clk_out falls), so clk_out never produces a runt pulse.
// Ports:
//   clk   : system clock
//   reset : asynchronous reset, active low
//   bus   : clk_div_sequencer_if.slave (enable, div_req/div_val/div_ack/div_err,
//           clk_out, tick, busy)
// Parameters:
//   CNT_W       : width of the ratio field and phase counter
//   DEFAULT_DIV : ratio loaded at reset (even, >= 2)
// Build option:
//   CLKDIV_ODD_RATIO_EN : when defined, odd ratios >= 3 are accepted
//   (high phase floor(N/2), low phase ceil(N/2)); otherwise odd ratios are rejected.
module clk_div_sequencer #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 32
) (
    input  logic               clk,
    input  logic               reset,
    clk_div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend;
    logic             r_clk_out;
    logic             r_rise;
    logic             r_ack;
    logic             r_err;

    logic [CNT_W-1:0] w_phase_len;
    logic             w_val_ok;
    logic             w_active;
    logic             w_last;
    logic             w_boundary;
    logic             w_sample;

`ifdef CLKDIV_ODD_RATIO_EN
    // Low phase takes the extra cycle of an odd ratio; the period is still N.
    assign w_phase_len = r_clk_out ? (r_cur_div >> 1) : (r_cur_div - (r_cur_div >> 1));
    assign w_val_ok    = (bus.div_val >= CNT_W'(2));
`else
    assign w_phase_len = r_cur_div >> 1;
    assign w_val_ok    = (bus.div_val >= CNT_W'(2)) && !bus.div_val[0];
`endif

    assign w_active   = (r_state != ST_IDLE);
    assign w_last     = w_active && (r_cnt >= (w_phase_len - CNT_W'(1)));
    // Boundary: last cycle of the high phase, clk_out falls on the next edge.
    assign w_boundary = w_last && r_clk_out;
    // One request at a time; the ack cycle itself is never re-sampled.
    assign w_sample   = bus.div_req && !r_pend && !r_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cur_div  <= CNT_W'(DEFAULT_DIV);
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_rise     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_rise <= 1'b0;

            // Ratio handshake. A valid request applies immediately when the
            // divider is idle or sitting on a boundary; otherwise it waits.
            if (w_sample) begin
                if (!w_val_ok) begin
                    r_ack <= 1'b1;
                    r_err <= 1'b1;
                end else if (!w_active || w_boundary) begin
                    r_cur_div <= bus.div_val;
                    r_ack     <= 1'b1;
                end else begin
                    r_pend     <= 1'b1;
                    r_pend_div <= bus.div_val;
                end
            end else if (r_pend && w_boundary) begin
                r_cur_div <= r_pend_div;
                r_pend    <= 1'b0;
                r_ack     <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_clk_out <= 1'b0;
                    r_cnt     <= '0;
                    if (bus.enable) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_clk_out <= ~r_clk_out;
                        r_rise    <= ~r_clk_out;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // STOP keeps the waveform running until clk_out falls,
                    // and re-enabling simply resumes it.
                    if (bus.enable) begin
                        r_state <= ST_RUN;
                    end else if (w_boundary) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_STOP;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clk_out <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.div_ack = r_ack;
    assign bus.div_err = r_err;
    assign bus.clk_out = r_clk_out;
    assign bus.tick    = r_rise && w_active;
    assign bus.busy    = w_active;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// tb/tb_clk_div_sequencer.sv - self-checking bench for clk_div_sequencer
module tb_clk_div_sequencer;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 32;
    localparam int NV          = 22;
`ifdef CLKDIV_ODD_RATIO_EN
    localparam bit ODD_EN = 1'b1;
`else
    localparam bit ODD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    clk_div_sequencer_if #(.CNT_W(CNT_W)) bus ();

    clk_div_sequencer #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             req;
        logic [CNT_W-1:0] val;
        logic [4:0]       exp;   // {clk_out, tick, busy, div_ack, div_err}
    } vec_t;

    vec_t vec [NV];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: position inside the current period of N cycles.
    // Low phase occupies positions 0..L-1 (L = ceil(N/2)), high phase L..N-1.
    int m_div, m_pos, m_pdiv;
    bit m_busy, m_pend, m_ack, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.div_req = 1'b0;
        bus.div_val = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n;
        n = 0;
        while (bus.busy !== lvl && n < 60) begin
            step();
            n++;
        end
        check(name, bus.busy, lvl);
    endtask

    task automatic measure_phase(input logic lvl, output int n);
        n = 0;
        while (bus.clk_out === lvl && n < 200) begin
            n++;
            step();
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.clk_out, bus.tick, bus.busy, bus.div_ack, bus.div_err};
    endfunction

    task automatic model_reset();
        m_div  = DEFAULT_DIV;
        m_pos  = 0;
        m_pdiv = 0;
        m_busy = 0;
        m_pend = 0;
        m_ack  = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic en, input logic req, input int val);
        bit boundary, sample, ok, a, e;
        boundary = m_busy && (m_pos == m_div - 1);
        sample   = req && !m_pend && !m_ack;
        ok       = (val >= 2) && (ODD_EN || (val % 2 == 0));
        a = 0;
        e = 0;
        if (sample) begin
            if (!ok) begin
                a = 1;
                e = 1;
            end else if (!m_busy || boundary) begin
                m_div = val;
                a     = 1;
            end else begin
                m_pend = 1;
                m_pdiv = val;
            end
        end else if (m_pend && boundary) begin
            m_div  = m_pdiv;
            m_pend = 0;
            a      = 1;
        end
        if (!m_busy) begin
            if (en) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end else if (boundary) begin
            m_pos = 0;
            if (!en) m_busy = 0;
        end else begin
            m_pos++;
        end
        m_ack = a;
        m_err = e;
    endtask

    function automatic logic [4:0] model_out();
        int  low_len;
        bit  c, t;
        low_len = m_div - m_div / 2;
        c = m_busy && (m_pos >= low_len);
        t = m_busy && (m_pos == low_len);
        return {c, t, m_busy, m_ack, m_err};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n, steps, ticks;
        logic early;

        vec[0]  = '{1'b0, 1'b1, 8'd8, 5'b00010};
        vec[1]  = '{1'b0, 1'b0, 8'd0, 5'b00000};
        vec[2]  = '{1'b0, 1'b1, 8'd0, 5'b00011};
        vec[3]  = '{1'b0, 1'b0, 8'd0, 5'b00000};
        vec[4]  = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[5]  = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[6]  = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[7]  = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[8]  = '{1'b1, 1'b0, 8'd0, 5'b11100};
        vec[9]  = '{1'b1, 1'b0, 8'd0, 5'b10100};
        vec[10] = '{1'b1, 1'b0, 8'd0, 5'b10100};
        vec[11] = '{1'b1, 1'b0, 8'd0, 5'b10100};
        vec[12] = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[13] = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[14] = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[15] = '{1'b1, 1'b0, 8'd0, 5'b00100};
        vec[16] = '{1'b1, 1'b0, 8'd0, 5'b11100};
        vec[17] = '{1'b0, 1'b0, 8'd0, 5'b10100};
        vec[18] = '{1'b0, 1'b0, 8'd0, 5'b10100};
        vec[19] = '{1'b0, 1'b0, 8'd0, 5'b10100};
        vec[20] = '{1'b0, 1'b0, 8'd0, 5'b00000};
        vec[21] = '{1'b0, 1'b0, 8'd0, 5'b00000};

        // Reset state
        do_reset();
        reset = 1'b0;
        #1;
        check("reset_outputs", outs(), 5'b00000);
        reset = 1'b1;
        step();

        // Table: accept 8 in IDLE, reject 0, run 4/4, stop during the high phase
        for (int i = 0; i < NV; i++) begin
            bus.enable  = vec[i].en;
            bus.div_req = vec[i].req;
            bus.div_val = vec[i].val;
            step();
            check($sformatf("vec%0d", i), outs(), vec[i].exp);
        end

        // Re-enable while in STOP: waveform continues without a gap (N=8)
        bus.enable = 1'b1;
        wait_busy(1'b1, "c_start_busy");
        measure_phase(1'b0, n);
        check("c_low_before_stop", n, 4);
        bus.enable = 1'b0;
        step();
        check("c_stop_busy1", bus.busy, 1'b1);
        step();
        check("c_stop_busy2", bus.busy, 1'b1);
        bus.enable = 1'b1;
        step();
        check("c_resumed_high", bus.clk_out, 1'b1);
        measure_phase(1'b1, n);
        check("c_high_tail", n, 1);
        measure_phase(1'b0, n);
        check("c_low_after", n, 4);
        measure_phase(1'b1, n);
        check("c_high_after", n, 4);

        // Ratio 7 in IDLE: rejected (even-only) or accepted (odd build)
        bus.enable = 1'b0;
        wait_busy(1'b0, "d_idle");
        bus.div_req = 1'b1;
        bus.div_val = 8'd7;
        step();
        check("d_ack", bus.div_ack, 1'b1);
        check("d_err", bus.div_err, ODD_EN ? 1'b0 : 1'b1);
        bus.div_req = 1'b0;
        step();
        bus.enable = 1'b1;
        wait_busy(1'b1, "d_busy");
        measure_phase(1'b0, n);
        check("d_low", n, 4);
        measure_phase(1'b1, n);
        check("d_high", n, ODD_EN ? 3 : 4);

        // Default ratio after reset: first rise 16 cycles after RUN entry
        do_reset();
        bus.enable = 1'b1;
        wait_busy(1'b1, "a_busy");
        measure_phase(1'b0, n);
        check("a_first_rise", n, 16);
        check("a_tick_on_rise", bus.tick, 1'b1);
        measure_phase(1'b1, n);
        check("a_high", n, 16);
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (bus.tick === 1'b1) ticks++;
        end
        check("a_ticks_64", ticks, 2);

        // Request 4 mid-high-phase at N=32: ack only at the falling boundary
        measure_phase(1'b0, n);
        step();
        step();
        step();
        bus.div_req = 1'b1;
        bus.div_val = 8'd4;
        steps = 0;
        early = 1'b0;
        while (bus.div_ack !== 1'b1 && steps < 40) begin
            step();
            steps++;
            if (bus.clk_out === 1'b0 && bus.div_ack !== 1'b1) early = 1'b1;
        end
        check("b_ack_latency", steps, 13);
        check("b_no_early_fall", early, 1'b0);
        check("b_ack_at_fall", bus.clk_out, 1'b0);
        check("b_err", bus.div_err, 1'b0);
        bus.div_req = 1'b0;
        measure_phase(1'b0, n);
        check("b_low_new", n, 2);
        measure_phase(1'b1, n);
        check("b_high_new", n, 2);

        // Reset while clk_out is high with a request pending
        measure_phase(1'b0, n);
        bus.div_req = 1'b1;
        bus.div_val = 8'd6;
        step();
        check("e_high_pending", {bus.clk_out, bus.div_ack}, 2'b10);
        reset = 1'b0;
        #1;
        check("e_async_clk_out", bus.clk_out, 1'b0);
        check("e_async_busy", bus.busy, 1'b0);
        bus.div_req = 1'b0;
        step();
        check("e_no_ack1", bus.div_ack, 1'b0);
        step();
        check("e_no_ack2", bus.div_ack, 1'b0);
        reset = 1'b1;
        wait_busy(1'b1, "e_busy");
        check("e_no_ack3", bus.div_ack, 1'b0);
        measure_phase(1'b0, n);
        check("e_default_ratio", n, 16);

        // Randomized run against the period-position model
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
            if (bus.div_req !== 1'b1) begin
                if ($urandom_range(0, 9) == 0) begin
                    bus.div_req = 1'b1;
                    bus.div_val = CNT_W'($urandom_range(0, 12));
                end
            end else if (m_ack && $urandom_range(0, 3) != 0) begin
                bus.div_req = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                bus.div_req = 1'b0;
            end
            @(posedge clk);
            model_step(bus.enable, bus.div_req, int'(bus.div_val));
            #1;
            check($sformatf("rand_cyc%0d", c), outs(), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
